// File: rtl/speed_tick_ctrl.sv
// speed_tick_ctrl: push-button selectable 2/5/10 Hz rate generator.
// Produces a registered 50% square wave (clko) plus a one-cycle tick on each
// clko rising edge, all in the clk domain. Rate changes requested by the
// debounced buttons are held pending and applied only on a half-period
// boundary so clko never produces a runt pulse.
module speed_tick_ctrl #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned DEB_CYC = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [1:0] speed,
  output logic       speed_pend,
  output logic       clko,
  output logic       tick
);

  localparam int unsigned HALF0 = CLK_HZ / 4;
  localparam int unsigned HALF1 = CLK_HZ / 10;
  localparam int unsigned HALF2 = CLK_HZ / 20;
  localparam int unsigned CW    = (HALF0 > 1) ? $clog2(HALF0) : 1;
  localparam int unsigned DW    = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;

  localparam logic [CW-1:0] LAST0   = CW'(HALF0 - 1);
  localparam logic [CW-1:0] LAST1   = CW'(HALF1 - 1);
  localparam logic [CW-1:0] LAST2   = CW'(HALF2 - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC);

  typedef enum logic [1:0] {
    SPD_2HZ  = 2'd0,
    SPD_5HZ  = 2'd1,
    SPD_10HZ = 2'd2
  } speed_e;

  // bit 0 = up, bit 1 = down
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_dn, btn_up};

  // Per-button synchronizer + debouncer. The stability counter restarts
  // whenever the synchronized level is about to change (s1 != s2), so it
  // counts cycles for which s2 has held its current value.
  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic          s1_q;
    logic          s2_q;
    logic          arm_q;
    logic [DW-1:0] cnt_q;
    logic          stable;

    assign stable   = (cnt_q == DEB_MAX);
    assign press[g] = arm_q & stable & s2_q;

    // Synchronize, count stable cycles, and arm/disarm the press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        arm_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q <= btn_raw[g];
        s2_q <= s1_q;
        if (s1_q != s2_q) begin
          cnt_q <= '0;
        end else if (!stable) begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (press[g]) begin
          arm_q <= 1'b0;
        end else if (stable && !s2_q) begin
          arm_q <= 1'b1;
        end
      end
    end
  end

  speed_e        speed_q;
  speed_e        pcode_q;
  logic          pend_q;
  logic          clko_q;
  logic          tick_q;
  logic [CW-1:0] cnt_q;

  speed_e        speed_d;
  speed_e        pcode_d;
  speed_e        target;
  speed_e        res;
  logic          pend_d;
  logic          bnd;
  logic          req;
  logic [CW-1:0] last;

  // Boundary detection and request/apply arbitration. A request landing on
  // a boundary is evaluated against the speed being applied in that cycle,
  // so it stays pending until the following boundary.
  always_comb begin
    last = LAST0;
    case (speed_q)
      SPD_2HZ: last = LAST0;
      SPD_5HZ: last = LAST1;
      default: last = LAST2;
    endcase
    bnd    = (cnt_q == last);
    req    = press[0] ^ press[1];
    target = pend_q ? pcode_q : speed_q;

    res = target;
    if (press[0]) begin
      case (target)
        SPD_2HZ: res = SPD_5HZ;
        default: res = SPD_10HZ;
      endcase
    end else begin
      case (target)
        SPD_10HZ: res = SPD_5HZ;
        default:  res = SPD_2HZ;
      endcase
    end

    speed_d = (bnd && pend_q) ? pcode_q : speed_q;
    pcode_d = pcode_q;
    pend_d  = bnd ? 1'b0 : pend_q;
    if (req && (res != target)) begin
      pcode_d = res;
      pend_d  = (res != speed_d);
    end
  end

  // Half-period counter, clko/tick generation and speed state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clko_q  <= 1'b0;
      tick_q  <= 1'b0;
      speed_q <= SPD_2HZ;
      pcode_q <= SPD_2HZ;
      pend_q  <= 1'b0;
    end else begin
      if (bnd) begin
        cnt_q  <= '0;
        clko_q <= ~clko_q;
        tick_q <= ~clko_q;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        tick_q <= 1'b0;
      end
      speed_q <= speed_d;
      pcode_q <= pcode_d;
      pend_q  <= pend_d;
    end
  end

  assign speed      = speed_q;
  assign speed_pend = pend_q;
  assign clko       = clko_q;
  assign tick       = tick_q;

endmodule
